// File: rtl/fuzz_result_misr.sv
// Capture-window MISR compactor for a wide result bus: folds each sample into a
// 32-bit signature, counts sample-to-sample changes, and hands the result off via valid/ready.
module fuzz_result_misr #(
  parameter int          Y_WIDTH   = 119,
  parameter int          CNT_WIDTH = 16,
  parameter logic [31:0] POLY      = 32'h04C11DB7,
  parameter logic [31:0] SEED      = 32'hFFFFFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_samples,
  input  logic [Y_WIDTH-1:0]   y,
  output logic                 busy,
  output logic                 sig_valid,
  input  logic                 sig_ready,
  output logic [31:0]          signature,
  output logic [CNT_WIDTH-1:0] toggle_count
);

  localparam int NCHUNK = (Y_WIDTH + 31) / 32;

  // ZERO is a one-cycle hold so an empty window reports one edge after start.
  typedef enum logic [1:0] {IDLE, CAPTURE, ZERO, REPORT} state_t;

  state_t                 state, state_n;
  logic [CNT_WIDTH-1:0]   n_lat, cnt;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic [Y_WIDTH-1:0]     prev_y;
  logic [NCHUNK*32-1:0]   y_pad;
  logic [31:0]            fold;
  logic [31:0]            sig_next;

  always_comb begin
    y_pad = '0;
    y_pad[Y_WIDTH-1:0] = y;
    fold = '0;
    for (int c = 0; c < NCHUNK; c++)
      fold = fold ^ y_pad[c*32 +: 32];
  end

  assign sig_next = ({signature[30:0], 1'b0} ^ (signature[31] ? POLY : 32'h0)) ^ fold;
  assign cnt_inc  = cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (num_samples == '0) ? ZERO : CAPTURE;
      CAPTURE: if (cnt_inc == n_lat) state_n = REPORT;
      ZERO:    state_n = REPORT;
      REPORT:  if (sig_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    sig_valid = (state == REPORT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_lat        <= '0;
      cnt          <= '0;
      prev_y       <= '0;
      signature    <= SEED;
      toggle_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          n_lat        <= num_samples;
          cnt          <= '0;
          signature    <= SEED;
          toggle_count <= '0;
        end
        CAPTURE: begin
          signature <= sig_next;
          // first sample of a window has nothing to compare against
          if (cnt != '0 && y != prev_y && toggle_count != {CNT_WIDTH{1'b1}})
            toggle_count <= toggle_count + 1'b1;
          prev_y <= y;
          cnt    <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fuzz_result_misr.sv
// Scoreboard bench for fuzz_result_misr: model results queued at start, checked at sig_valid.
module tb_fuzz_result_misr;
  localparam int YW = 119;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          sig_ready = 1'b0;
  logic [CW-1:0] num_samples = '0;
  logic [YW-1:0] y = '0;
  logic          busy, sig_valid;
  logic [31:0]   signature;
  logic [CW-1:0] toggle_count;

  int checks = 0;
  int passed = 0;

  logic [YW-1:0] ys[$];
  logic [31:0]   exp_sig_q[$];
  logic [CW-1:0] exp_tog_q[$];

  fuzz_result_misr dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .y(y),
    .busy(busy), .sig_valid(sig_valid), .sig_ready(sig_ready),
    .signature(signature), .toggle_count(toggle_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one window over ys[0..n-1]; ready held low for ready_delay cycles after valid.
  task automatic run_window(input int n, input int ready_delay, input bit poke_start,
                            input string tag, output logic [31:0] got_sig);
    logic [31:0]   s, f, es;
    logic [CW-1:0] t, et;
    logic [YW-1:0] v, pv;
    s = 32'hFFFFFFFF;
    t = '0;
    pv = '0;
    for (int k = 0; k < n; k++) begin
      v = ys[k];
      f = '0;
      for (int b = 0; b < YW; b++) f[b % 32] = f[b % 32] ^ v[b];
      s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
      if (k > 0 && v !== pv) t = t + 1'b1;
      pv = v;
    end
    exp_sig_q.push_back(s);
    exp_tog_q.push_back(t);

    sig_ready   = (ready_delay == 0);
    start       = 1'b1;
    num_samples = CW'(n);
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_start got=%b want=1", tag, busy);
    else passed++;
    if (n > 0) y = ys[0];
    for (int i = 0; i < n; i++) begin
      checks++;
      if (sig_valid !== 1'b0) $display("FAIL %s early_valid sample=%0d got=%b want=0", tag, i, sig_valid);
      else passed++;
      step();
      if (i + 1 < n) y = ys[i+1];
    end
    if (n == 0) begin
      checks++;
      if (sig_valid !== 1'b0) $display("FAIL %s zero_early_valid got=%b want=0", tag, sig_valid);
      else passed++;
      step();
    end

    es = exp_sig_q.pop_front();
    et = exp_tog_q.pop_front();
    checks++;
    if (sig_valid !== 1'b1) $display("FAIL %s valid_rise got=%b want=1", tag, sig_valid);
    else passed++;
    checks++;
    if (signature !== es) $display("FAIL %s signature got=%h want=%h", tag, signature, es);
    else passed++;
    checks++;
    if (toggle_count !== et) $display("FAIL %s toggle_count got=%0d want=%0d", tag, toggle_count, et);
    else passed++;
    got_sig = signature;

    for (int d = 0; d < ready_delay; d++) begin
      if (poke_start && d == 1) begin
        start = 1'b1;
        num_samples = '0;
      end
      step();
      start = 1'b0;
      checks++;
      if (sig_valid !== 1'b1 || signature !== es)
        $display("FAIL %s hold cyc=%0d valid=%b sig=%h want valid=1 sig=%h", tag, d, sig_valid, signature, es);
      else passed++;
    end

    sig_ready = 1'b1;
    step();
    sig_ready = 1'b0;
    checks++;
    if (sig_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s handshake valid=%b busy=%b want 0/0", tag, sig_valid, busy);
    else passed++;
    checks++;
    if (signature !== es || toggle_count !== et)
      $display("FAIL %s post_hold sig=%h tog=%0d want sig=%h tog=%0d", tag, signature, toggle_count, es, et);
    else passed++;
  endtask

  task automatic test_reset();
    logic [31:0] g;
    step();
    checks++;
    if (busy !== 1'b0 || sig_valid !== 1'b0 || signature !== 32'hFFFFFFFF || toggle_count !== '0)
      $display("FAIL reset_initial busy=%b valid=%b sig=%h tog=%0d want 0/0/ffffffff/0",
               busy, sig_valid, signature, toggle_count);
    else passed++;
    rst = 1'b0;
    step();
    start = 1'b1;
    num_samples = 16'd10;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      y = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || sig_valid !== 1'b0 || signature !== 32'hFFFFFFFF || toggle_count !== '0)
      $display("FAIL reset_async busy=%b valid=%b sig=%h tog=%0d want 0/0/ffffffff/0",
               busy, sig_valid, signature, toggle_count);
    else passed++;
    step();
    rst = 1'b0;
    y = '0;
    step();
    checks++;
    if (busy !== 1'b0 || sig_valid !== 1'b0 || signature !== 32'hFFFFFFFF || toggle_count !== '0)
      $display("FAIL reset_release busy=%b valid=%b sig=%h tog=%0d", busy, sig_valid, signature, toggle_count);
    else passed++;
    ys = '{};
    ys.push_back('0);
    run_window(1, 0, 1'b0, "reset_n1", g);
    checks++;
    if (g !== 32'hFB3EE249) $display("FAIL reset_n1_const got=%h want=fb3ee249", g);
    else passed++;
  endtask

  task automatic test_zero_window();
    logic [31:0] g;
    ys = '{};
    run_window(0, 0, 1'b0, "zero", g);
    checks++;
    if (g !== 32'hFFFFFFFF) $display("FAIL zero_const got=%h want=ffffffff", g);
    else passed++;
  endtask

  task automatic test_all_ones();
    logic [31:0] g;
    ys = '{};
    ys.push_back({YW{1'b1}});
    run_window(1, 0, 1'b0, "ones", g);
    checks++;
    if (g !== 32'h04BEE249) $display("FAIL ones_const got=%h want=04bee249", g);
    else passed++;
  endtask

  task automatic test_toggle();
    logic [31:0] g;
    ys = '{};
    ys.push_back(YW'(0)); ys.push_back(YW'(0)); ys.push_back(YW'(5)); ys.push_back(YW'(5));
    run_window(4, 0, 1'b0, "toggle", g);
    checks++;
    if (toggle_count !== 16'd1) $display("FAIL toggle_const got=%0d want=1", toggle_count);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] g;
    ys = '{};
    for (int i = 0; i < 6; i++) ys.push_back({$urandom, $urandom, $urandom, $urandom});
    run_window(6, 5, 1'b1, "backpressure", g);
    step();
    checks++;
    if (busy !== 1'b0) $display("FAIL backpressure_no_queue busy got=%b want=0", busy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] g1, g2;
    ys = '{};
    for (int i = 0; i < 8; i++) ys.push_back({$urandom, $urandom, $urandom, $urandom});
    run_window(8, 0, 1'b0, "b2b_first", g1);
    run_window(8, 2, 1'b0, "b2b_second", g2);
    checks++;
    if (g1 !== g2) $display("FAIL b2b_repeat got=%h want=%h", g2, g1);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_window();
    test_all_ones();
    test_toggle();
    test_backpressure();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/fuzz_result_misr.md
# fuzz_result_misr

Downstream capture stage for the fuzz simulation bench. It samples the DUT's 119-bit result bus `y` on every clock edge during a programmed capture window and compacts the samples into a 32-bit MISR signature. It also counts the cycles on which `y` changed. It then presents the signature through a valid/ready handshake, so simulation runs can be compared by signature instead of by full strobe dumps.

## Interface
- `Y_WIDTH`, 119: width of the result bus being compacted.
- `CNT_WIDTH`, 16: width of the sample-count and toggle-count fields.
- `POLY`, 32'h04C11DB7: MISR feedback polynomial.
- `SEED`, 32'hFFFFFFFF: signature value loaded at start and at reset.

Ports:
- `clk` input 1: sole clock; all logic on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle request to begin a capture window; honoured only in IDLE.
- `num_samples` input CNT_WIDTH: window length, latched when `start` is accepted.
- `y` input Y_WIDTH: DUT result bus, sampled every cycle in CAPTURE.
- `busy` output 1: high in CAPTURE and REPORT.
- `sig_valid` output 1: signature available.
- `sig_ready` input 1: consumer accepts the signature.
- `signature` output 32: MISR result.
- `toggle_count` output CNT_WIDTH: number of sampled cycles where `y` differed from the previous sample; saturates.

## Operation
- Reset values:
  - FSM = IDLE
  - `busy`=0, `sig_valid`=0
  - `signature`=SEED, `toggle_count`=0
  - internal sample counter = 0, previous-y register = 0
- **IDLE**, `start`=1:
  - latch `num_samples`
  - `signature`←SEED, `toggle_count`←0
  - if `num_samples`==0, go to REPORT; otherwise go to CAPTURE.
- **CAPTURE**, each cycle:
  - fold = XOR of `y` split into 32-bit chunks from bit 0 upward; the top chunk is zero-padded. For 119 bits this is 3 full chunks plus 23 bits.
  - `signature` ← ({sig[30:0],1'b0} ^ (sig[31] ? POLY : 0)) ^ fold.
  - From the second sample on, if `y` != previous-y, increment `toggle_count`, saturating at all-ones.
  - previous-y ← `y`; sample counter increments.
  - When the counter reaches the latched count, go to REPORT.
- **REPORT**:
  - `sig_valid`=1; `signature` and `toggle_count` are held stable.
  - On `sig_valid && sig_ready` at posedge, go to IDLE and drop `sig_valid`.
- `start` in CAPTURE or REPORT is ignored; no queuing.
- After the handshake, `signature` and `toggle_count` keep their final values until the next accepted `start`.
- `rst` asserted in any state returns all state to reset values immediately, asynchronously. Any partial signature is discarded.

## Timing
- `start` accepted at edge T. The first `y` sample is taken at edge T+1; the Nth sample at edge T+N.
- `sig_valid` is high in the cycle after edge T+N; it is a registered output.
- For `num_samples`==0, `sig_valid` is high after edge T+1 with `signature`=SEED.
- `busy` rises after edge T and falls after the handshake edge.
- If `sig_ready` is already high when `sig_valid` rises, the transfer completes at the next edge. `sig_valid` is therefore high for exactly 1 cycle.
- A new `start` is honoured in the first IDLE cycle after the handshake; the minimum gap is 1 cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset values:** assert `rst` mid-CAPTURE (N=10, after 4 samples), then release.
  - Required: `busy`=0, `sig_valid`=0, `signature`=32'hFFFFFFFF, `toggle_count`=0.
  - A following `start` with N=1 and `y`=0 gives 32'hFB3EE249.
- **Zero window:** `start`, `num_samples`=0, `sig_ready`=1.
  - Required: `sig_valid` pulses 1 cycle after edge T+1; `signature`=32'hFFFFFFFF; `toggle_count`=0.
- **Single all-ones sample:** N=1, `y`=all ones.
  - Required: `signature`=32'h04BEE249 (fold=32'hFF800000); `toggle_count`=0.
- **Toggle counting:** N=4, `y`=0,0,5,5 on consecutive sample edges.
  - Required: `toggle_count`=1; `sig_valid` rises after edge T+4.
- **Handshake backpressure:** hold `sig_ready`=0 for 5 cycles after `sig_valid` rises, then raise it.
  - Required: `sig_valid` and `signature` are stable for all 5 cycles; IDLE is entered at the ready edge.
  - A `start` pulsed during REPORT is ignored.
- **Back-to-back windows:** second `start` in the first IDLE cycle after the handshake.
  - Required: `signature` restarts from SEED.
  - Running the identical `y` sequence twice gives identical signatures.
